ttm4_register_bank: RTL and testbench
=====================================

# ttm4_register_bank

Register section of the TTM4 emulator: the receiving end of the 4-bit data bus driven by the 74HC257 selector/ALU path. It holds registers A, B, the output port latch, the program counter (PC) and the carry flag, capturing bus data on the rising clock edge according to active-low load strobes from the instruction decoder. Each 4-bit register is an instance of an emulated 74HC161, so behaviour matches the discrete-chip TD4-style board cycle for cycle.

## Interface
- WIDTH, 4: register and bus width; only 4 is supported.
- PC_RESET, 4'h0: PC value after reset.
- CLK  in  1  system clock; all state changes on rising edge.
- nRST  in  1  asynchronous, active-low reset; clears every register and the carry flag.
- DATA  in  WIDTH  bus data from the selector/adder path.
- nLOAD  in  4  active-low load strobes, one per register: [0]=A, [1]=B, [2]=OUT, [3]=PC.
- HALT  in  1  high freezes PC counting and carry-flag update.
- CARRY_IN  in  1  adder carry-out, sampled into the carry flag.
- A_Q  out  WIDTH  register A.
- B_Q  out  WIDTH  register B.
- OUT_Q  out  WIDTH  output port latch.
- PC_Q  out  WIDTH  program counter.
- C_FLAG  out  1  carry flag.
- PC_RCO  out  1  PC ripple carry out; high when PC_Q==4'hF and HALT==0.

## Operation
- Reset (nRST low, asynchronous, independent of CLK): A_Q=B_Q=OUT_Q=0, PC_Q=PC_RESET, C_FLAG=0, PC_RCO=0 (PC_RCO=1 only if PC_RESET=4'hF and HALT=0). Reset held low overrides every other input; deassertion takes effect from the next rising edge.
- A, B, OUT: on a rising edge, a register whose nLOAD bit is low loads DATA; otherwise it holds. These registers never count.
- PC, on a rising edge, in priority order:
  - nLOAD[3] low: load DATA. Load wins over HALT.
  - Otherwise, HALT low: increment modulo 16 (4'hF to 4'h0).
  - Otherwise: hold.
- C_FLAG: loads CARRY_IN on every rising edge with HALT low; holds while HALT is high.
- Multiple nLOAD bits may be low at once. Every selected register loads the same DATA, with no priority between registers, matching the wired board.
- DATA is sampled as-is. Loading while the bus is floating stores x/z; the emulator does not guard against this.
- PC_RCO is combinational from PC_Q and HALT.

## Timing
- Load latency: DATA and nLOAD set up before rising edge n, value visible on outputs after edge n. This is one cycle.
- PC increment: visible one cycle after the edge.
- Outputs are registered (except PC_RCO), with no combinational path from DATA to any *_Q.
- Asynchronous clear is immediate. A reset asserted mid-cycle discards any pending load.
- Wrap-around: with PC_Q=4'hF and HALT=0, PC_RCO=1, and the next edge gives PC_Q=4'h0, PC_RCO=0.

## Structure
- Sub-module LOGIC_74HC161, one per register (four instances).
  - Ports: CLK, nCLR (async, active-low), nLOAD, ENP, ENT, D[3:0], Q[3:0], RCO.
  - Behaviour: synchronous load; counts when ENP&ENT; RCO = ENT & (Q==4'hF).
  - A/B/OUT instances tie ENP=ENT=0. The PC instance ties ENP=ENT=~HALT.
  - PC_RESET is applied by a parameter on the PC instance's clear value.
- Carry flag is a single flip-flop, modelled as a 74HC74-equivalent always block in the top.
- Shared package ttm4_pkg holds:
  - TTM4_WIDTH=4.
  - Load index constants LD_A=0, LD_B=1, LD_OUT=2, LD_PC=3.
  - Reset constant PC_RESET_DEFAULT=4'h0.

## Test plan
- Async reset: load A=4'h9 and PC=4'h7, then pulse nRST low between edges. All *_Q go to 0 immediately, before the next edge, and C_FLAG=0.
- Individual loads: DATA=4'h5 with nLOAD=4'b1110 gives A_Q=5 and others unchanged. Then DATA=4'hA with nLOAD=4'b1101 gives B_Q=A, A_Q=5.
- Simultaneous load: DATA=4'h3 with nLOAD=4'b0000 gives A_Q=B_Q=OUT_Q=PC_Q=3 after one edge.
- PC count and wrap: nLOAD=4'hF, HALT=0, 17 edges from reset. Expect PC sequence 1..F,0,1, with PC_RCO high exactly while PC_Q=F.
- HALT vs load: HALT=1 with PC=4'h4 for 3 edges gives PC stays 4 and C_FLAG holds. HALT=1 with nLOAD[3]=0 and DATA=4'hC gives PC_Q=C.
- Carry flag: CARRY_IN=1 at an edge gives C_FLAG=1 next cycle. CARRY_IN=0 with HALT=1 gives C_FLAG stays 1. HALT=0 then gives C_FLAG=0.

Source files
------------

// File: rtl/ttm4_pkg.sv
// Shared constants for the TTM4 emulator: bus width, load-strobe bit positions
// and the program counter's power-on value.
package ttm4_pkg;

  localparam int TTM4_WIDTH = 4;

  localparam int LD_A   = 0;
  localparam int LD_B   = 1;
  localparam int LD_OUT = 2;
  localparam int LD_PC  = 3;

  localparam logic [3:0] PC_RESET_DEFAULT = 4'h0;

endpackage

// File: rtl/ttm4_register_bank_74hc161.sv
// Emulated 74HC161 4-bit synchronous counter: async clear, synchronous
// load, count when ENP&ENT, ripple carry gated by ENT only.
module LOGIC_74HC161
  import ttm4_pkg::*;
#(
  parameter int                 WIDTH     = TTM4_WIDTH,
  parameter logic [WIDTH-1:0]   CLR_VALUE = '0
) (
  input  logic             CLK,
  input  logic             nCLR,
  input  logic             nLOAD,
  input  logic             ENP,
  input  logic             ENT,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO
);

  // Load has priority over counting, as on the real chip.
  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      Q <= CLR_VALUE;
    end else if (!nLOAD) begin
      Q <= D;
    end else if (ENP && ENT) begin
      Q <= Q + WIDTH'(1);
    end
  end

  // RCO ignores ENP so a held PC still reports terminal count if ENT is high.
  assign RCO = ENT & (Q == {WIDTH{1'b1}});

endmodule

// File: rtl/ttm4_register_bank.sv
// TTM4 register section: A, B, output latch and PC as 74HC161 instances on
// the shared 4-bit bus, plus the carry flag flip-flop.
module ttm4_register_bank
  import ttm4_pkg::*;
#(
  parameter int               WIDTH    = TTM4_WIDTH,
  parameter logic [WIDTH-1:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] DATA,
  input  logic [3:0]       nLOAD,
  input  logic             HALT,
  input  logic             CARRY_IN,
  output logic [WIDTH-1:0] A_Q,
  output logic [WIDTH-1:0] B_Q,
  output logic [WIDTH-1:0] OUT_Q,
  output logic [WIDTH-1:0] PC_Q,
  output logic             C_FLAG,
  output logic             PC_RCO
);

  logic pc_en;
  logic unused_rco_a;
  logic unused_rco_b;
  logic unused_rco_out;

  assign pc_en = ~HALT;

  // Data registers have their count enables tied low: load or hold only.
  LOGIC_74HC161 #(.WIDTH(WIDTH), .CLR_VALUE('0)) u_reg_a (
    .CLK(CLK), .nCLR(nRST), .nLOAD(nLOAD[LD_A]), .ENP(1'b0), .ENT(1'b0),
    .D(DATA), .Q(A_Q), .RCO(unused_rco_a)
  );

  LOGIC_74HC161 #(.WIDTH(WIDTH), .CLR_VALUE('0)) u_reg_b (
    .CLK(CLK), .nCLR(nRST), .nLOAD(nLOAD[LD_B]), .ENP(1'b0), .ENT(1'b0),
    .D(DATA), .Q(B_Q), .RCO(unused_rco_b)
  );

  LOGIC_74HC161 #(.WIDTH(WIDTH), .CLR_VALUE('0)) u_reg_out (
    .CLK(CLK), .nCLR(nRST), .nLOAD(nLOAD[LD_OUT]), .ENP(1'b0), .ENT(1'b0),
    .D(DATA), .Q(OUT_Q), .RCO(unused_rco_out)
  );

  LOGIC_74HC161 #(.WIDTH(WIDTH), .CLR_VALUE(PC_RESET)) u_reg_pc (
    .CLK(CLK), .nCLR(nRST), .nLOAD(nLOAD[LD_PC]), .ENP(pc_en), .ENT(pc_en),
    .D(DATA), .Q(PC_Q), .RCO(PC_RCO)
  );

  // Carry flag behaves like a 74HC74 whose clock is qualified by ~HALT.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      C_FLAG <= 1'b0;
    end else if (!HALT) begin
      C_FLAG <= CARRY_IN;
    end
  end

endmodule

// File: tb/tb_ttm4_register_bank.sv
// Bench for ttm4_register_bank: directed register-section scenarios followed
// by randomized traffic, all checked against a register-level reference model.
module tb_ttm4_register_bank;
  import ttm4_pkg::*;

  logic       CLK = 1'b0;
  logic       nRST;
  logic [3:0] DATA;
  logic [3:0] nLOAD;
  logic       HALT;
  logic       CARRY_IN;
  logic [3:0] A_Q, B_Q, OUT_Q, PC_Q;
  logic       C_FLAG, PC_RCO;

  int checks   = 0;
  int failures = 0;

  // Reference state: one value per architectural register.
  logic [3:0] m_a, m_b, m_out, m_pc;
  logic       m_c;
  logic [3:0] exp_q[$];

  ttm4_register_bank dut (
    .CLK(CLK), .nRST(nRST), .DATA(DATA), .nLOAD(nLOAD), .HALT(HALT),
    .CARRY_IN(CARRY_IN), .A_Q(A_Q), .B_Q(B_Q), .OUT_Q(OUT_Q), .PC_Q(PC_Q),
    .C_FLAG(C_FLAG), .PC_RCO(PC_RCO)
  );

  // ---- clock / reset ----
  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_a = 4'h0; m_b = 4'h0; m_out = 4'h0; m_pc = PC_RESET_DEFAULT; m_c = 1'b0;
  endtask

  // ---- scoreboard ----
  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, ".a"},   A_Q,   m_a);
    check({ph, ".b"},   B_Q,   m_b);
    check({ph, ".out"}, OUT_Q, m_out);
    check({ph, ".pc"},  PC_Q,  m_pc);
    check({ph, ".c"},   {3'b0, C_FLAG}, {3'b0, m_c});
    check({ph, ".rco"}, {3'b0, PC_RCO}, {3'b0, (m_pc == 4'hF) && (HALT == 1'b0)});
  endtask

  // ---- driver: one clock edge, called at a falling edge ----
  task automatic cycle(input logic [3:0] d, input logic [3:0] nl, input logic h,
                       input logic ci, input string ph);
    DATA = d; nLOAD = nl; HALT = h; CARRY_IN = ci;
    @(posedge CLK);
    if (!nl[LD_A])   m_a   = d;
    if (!nl[LD_B])   m_b   = d;
    if (!nl[LD_OUT]) m_out = d;
    if (!nl[LD_PC])  m_pc  = d;
    else if (!h)     m_pc  = 4'((int'(m_pc) + 1) % 16);
    if (!h)          m_c   = ci;
    @(negedge CLK);
    check_all(ph);
  endtask

  // Reset pulse entirely between edges; sampled while low.
  task automatic reset_pulse(input string ph);
    #2 nRST = 1'b0;
    #1 model_reset();
    check_all(ph);
    #1 nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0; DATA = 4'h0; nLOAD = 4'hF; HALT = 1'b1; CARRY_IN = 1'b0;
    model_reset();
    @(negedge CLK); @(negedge CLK);
    check_all("reset");
    nRST = 1'b1;

    // Async clear between edges
    cycle(4'h9, 4'b1110, 1'b0, 1'b1, "ld_a9");
    cycle(4'h7, 4'b0111, 1'b1, 1'b0, "ld_pc7");
    check("pre_rst_a", A_Q, 4'h9);
    check("pre_rst_pc", PC_Q, 4'h7);
    reset_pulse("async_rst");

    // Reset held across an edge overrides every load and count
    @(negedge CLK);
    DATA = 4'hF; nLOAD = 4'b0000; HALT = 1'b0; CARRY_IN = 1'b1; nRST = 1'b0;
    @(posedge CLK); @(negedge CLK);
    model_reset();
    check_all("rst_hold");
    nRST = 1'b1;

    // PC count and wrap: 17 edges from reset
    for (int i = 1; i <= 17; i++) exp_q.push_back(4'(i % 16));
    for (int i = 0; i < 17; i++) begin
      cycle(4'($urandom_range(0, 15)), 4'hF, 1'b0, 1'($urandom_range(0, 1)), "count");
      check("pc_seq", PC_Q, exp_q.pop_front());
    end

    // Individual and simultaneous loads
    cycle(4'h5, 4'b1110, 1'b1, 1'b0, "ld_a5");
    check("a_is_5", A_Q, 4'h5);
    cycle(4'hA, 4'b1101, 1'b1, 1'b0, "ld_ba");
    check("b_is_a", B_Q, 4'hA);
    check("a_kept_5", A_Q, 4'h5);
    cycle(4'h3, 4'b0000, 1'b1, 1'b0, "ld_all3");
    check("out_is_3", OUT_Q, 4'h3);

    // HALT vs load, with the carry flag set beforehand
    cycle(4'h4, 4'b0111, 1'b0, 1'b1, "ld_pc4");
    for (int i = 0; i < 3; i++) begin
      cycle(4'($urandom_range(0, 15)), 4'hF, 1'b1, 1'($urandom_range(0, 1)), "halt");
      check("halt_pc4", PC_Q, 4'h4);
      check("halt_c1", {3'b0, C_FLAG}, 4'h1);
    end
    cycle(4'hC, 4'b0111, 1'b1, 1'b0, "halt_ld");
    check("halt_ld_pcc", PC_Q, 4'hC);

    // Carry flag set / hold / clear
    cycle(4'h0, 4'hF, 1'b0, 1'b1, "c_set");
    check("c_set", {3'b0, C_FLAG}, 4'h1);
    cycle(4'h0, 4'hF, 1'b1, 1'b0, "c_hold");
    check("c_hold", {3'b0, C_FLAG}, 4'h1);
    cycle(4'h0, 4'hF, 1'b0, 1'b0, "c_clr");
    check("c_clr", {3'b0, C_FLAG}, 4'h0);

    // Randomized traffic with occasional async resets
    for (int i = 0; i < 400; i++) begin
      cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), "rand");
      if ($urandom_range(0, 49) == 0) reset_pulse("rand_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
